// File: rtl/wifi_rx_symbol_framer.sv
// RX OFDM symbol framer: drops preamble and cyclic prefix, forwards 64 useful samples per symbol.
// Optional idle-timeout abort is enabled with `define WIFI_RX_TIMEOUT_EN.
module wifi_rx_symbol_framer #(
    parameter int PREAMBLE_LEN = 320,
    parameter int CP_LEN       = 16,
    parameter int FFT_LEN      = 64,
    parameter int SYM_CNT_W    = 16,
    parameter int TIMEOUT      = 1024,
    parameter int DATA_W       = 12
) (
    input  logic                     clk_ifft,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] data_in_re,
    input  logic signed [DATA_W-1:0] data_in_im,
    input  logic [SYM_CNT_W-1:0]     num_sym,
    input  logic                     en_Rx_irq,
    input  logic                     clear_Rx_irq,
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] data_out_re,
    output logic signed [DATA_W-1:0] data_out_im,
    output logic                     sym_start,
    output logic                     sym_end,
    output logic                     last_sym,
    output logic                     finished,
    output logic                     busy,
    output logic                     Rx_irq,
    output logic                     rx_err
);

    localparam int MAX_AB  = (PREAMBLE_LEN > CP_LEN) ? PREAMBLE_LEN : CP_LEN;
    localparam int MAX_LEN = (MAX_AB > FFT_LEN) ? MAX_AB : FFT_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] CP_LAST  = CNT_W'(CP_LEN - 1);
    localparam logic [CNT_W-1:0] FFT_LAST = CNT_W'(FFT_LEN - 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, CP, PAYLOAD, DONE} state_t;

    state_t                    state_q, state_n;
    logic [CNT_W-1:0]          cnt_q, cnt_n;
    logic [SYM_CNT_W-1:0]      sym_cnt_q, sym_cnt_n;
    logic [SYM_CNT_W-1:0]      num_sym_q, num_sym_n;
    logic                      busy_q, busy_n;
    logic                      err_set;

    logic                      vld_p1, vld_n;
    logic signed [DATA_W-1:0]  re_p1, re_n;
    logic signed [DATA_W-1:0]  im_p1, im_n;
    logic                      ss_p1, ss_n;
    logic                      se_p1, se_n;
    logic                      ls_p1, ls_n;
    logic                      fin_p1, fin_n;
    logic                      irq_q;

`ifdef WIFI_RX_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt_q;
    logic              rx_err_q;

    // DONE is excluded so a completed frame never reports a timeout
    assign err_set = busy_q && !valid_in && (state_q != DONE) && (idle_cnt_q == IDLE_LAST);

    always_ff @(posedge clk_ifft or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            if (valid_in || !busy_q || err_set)
                idle_cnt_q <= '0;
            else
                idle_cnt_q <= idle_cnt_q + 1'b1;
            if (err_set)
                rx_err_q <= 1'b1;
            else if (clear_Rx_irq)
                rx_err_q <= 1'b0;
        end
    end

    assign rx_err = rx_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err_set        = 1'b0;
    assign rx_err         = 1'b0;
`endif

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        sym_cnt_n = sym_cnt_q;
        num_sym_n = num_sym_q;
        busy_n    = busy_q;
        vld_n     = 1'b0;
        re_n      = re_p1;
        im_n      = im_p1;
        ss_n      = 1'b0;
        se_n      = 1'b0;
        ls_n      = 1'b0;
        fin_n     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    num_sym_n = num_sym;
                    busy_n    = 1'b1;
                    cnt_n     = CNT_W'(1);
                    sym_cnt_n = '0;
                    state_n   = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (valid_in) begin
                    if (cnt_q == PRE_LAST) begin
                        cnt_n = '0;
                        if (num_sym_q != '0) begin
                            state_n = CP;
                        end else begin
                            state_n = DONE;
                            fin_n   = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            CP: begin
                if (valid_in) begin
                    if (cnt_q == CP_LAST) begin
                        cnt_n   = '0;
                        state_n = PAYLOAD;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (valid_in) begin
                    vld_n = 1'b1;
                    re_n  = data_in_re;
                    im_n  = data_in_im;
                    ss_n  = (cnt_q == '0);
                    se_n  = (cnt_q == FFT_LAST);
                    ls_n  = (sym_cnt_q == num_sym_q - 1'b1);
                    if (cnt_q == FFT_LAST) begin
                        cnt_n     = '0;
                        sym_cnt_n = sym_cnt_q + 1'b1;
                        if (ls_n) begin
                            state_n = DONE;
                            fin_n   = 1'b1;
                        end else begin
                            state_n = CP;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
        if (err_set) begin
            state_n = IDLE;
            cnt_n   = '0;
            busy_n  = 1'b0;
        end
    end

    // stage p1: registered control state and forwarded sample
    always_ff @(posedge clk_ifft or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sym_cnt_q <= '0;
            num_sym_q <= '0;
            busy_q    <= 1'b0;
            vld_p1    <= 1'b0;
            re_p1     <= '0;
            im_p1     <= '0;
            ss_p1     <= 1'b0;
            se_p1     <= 1'b0;
            ls_p1     <= 1'b0;
            fin_p1    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sym_cnt_q <= sym_cnt_n;
            num_sym_q <= num_sym_n;
            busy_q    <= busy_n;
            vld_p1    <= vld_n;
            re_p1     <= re_n;
            im_p1     <= im_n;
            ss_p1     <= ss_n;
            se_p1     <= se_n;
            ls_p1     <= ls_n;
            fin_p1    <= fin_n;
            if (en_Rx_irq && (fin_p1 || err_set))
                irq_q <= 1'b1;
            else if (clear_Rx_irq)
                irq_q <= 1'b0;
        end
    end

    assign valid_out   = vld_p1;
    assign data_out_re = re_p1;
    assign data_out_im = im_p1;
    assign sym_start   = ss_p1;
    assign sym_end     = se_p1;
    assign last_sym    = ls_p1;
    assign finished    = fin_p1;
    assign busy        = busy_q;
    assign Rx_irq      = irq_q;

endmodule

// File: tb/tb_wifi_rx_symbol_framer.sv
// Directed bench for wifi_rx_symbol_framer: ramp frames, gapped input, zero-symbol frame,
// interrupt set/clear, mid-frame reset and long input stall.
module tb_wifi_rx_symbol_framer;

    localparam int PRE = 320;
    localparam int CPL = 16;
    localparam int SYM = 80;

    logic              clk_ifft = 1'b0;
    logic              reset;
    logic              valid_in;
    logic signed [11:0] data_in_re;
    logic signed [11:0] data_in_im;
    logic [15:0]       num_sym;
    logic              en_Rx_irq;
    logic              clear_Rx_irq;
    logic              valid_out;
    logic signed [11:0] data_out_re;
    logic signed [11:0] data_out_im;
    logic              sym_start;
    logic              sym_end;
    logic              last_sym;
    logic              finished;
    logic              busy;
    logic              Rx_irq;
    logic              rx_err;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] last_re = '0;
    logic [11:0] last_im = '0;

    always #5 clk_ifft = ~clk_ifft;

    wifi_rx_symbol_framer dut (
        .clk_ifft     (clk_ifft),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in_re   (data_in_re),
        .data_in_im   (data_in_im),
        .num_sym      (num_sym),
        .en_Rx_irq    (en_Rx_irq),
        .clear_Rx_irq (clear_Rx_irq),
        .valid_out    (valid_out),
        .data_out_re  (data_out_re),
        .data_out_im  (data_out_im),
        .sym_start    (sym_start),
        .sym_end      (sym_end),
        .last_sym     (last_sym),
        .finished     (finished),
        .busy         (busy),
        .Rx_irq       (Rx_irq),
        .rx_err       (rx_err)
    );

    // Feeds a ramp frame (re=idx, im=-idx); every accepted sample is checked one cycle later.
    task automatic drive_frame(input int n, input bit toggle, input int abort_at,
                               input int stall_at, input bit clr_at_done);
        int total;
        total = PRE + n * SYM;
        num_sym = 16'(n);
        for (int idx = 0; idx < total; idx++) begin
            int r;
            int pos;
            int sn;
            bit exp_v;
            bit exp_ss;
            bit exp_se;
            bit exp_ls;
            bit exp_fin;
            logic [11:0] re_v;
            logic [11:0] im_v;
            re_v = 12'(idx);
            im_v = 12'(0) - re_v;
            r = idx - PRE;
            if (idx >= PRE) begin
                pos = r % SYM;
                sn  = r / SYM;
            end else begin
                pos = 0;
                sn  = 0;
            end
            exp_v   = (idx >= PRE) && (pos >= CPL);
            exp_ss  = exp_v && (pos == CPL);
            exp_se  = exp_v && (pos == SYM - 1);
            exp_ls  = exp_v && (sn == n - 1);
            exp_fin = (idx == total - 1);

            valid_in   = 1'b1;
            data_in_re = re_v;
            data_in_im = im_v;
            @(posedge clk_ifft); #1;
            valid_in = 1'b0;
            num_sym  = 16'hA5A5;
            if (exp_v) begin
                last_re = re_v;
                last_im = im_v;
            end
            checks++;
            if (valid_out !== exp_v) begin
                errors++;
                $display("FAIL valid_out n=%0d idx=%0d got %b want %b", n, idx, valid_out, exp_v);
            end
            checks++;
            if (data_out_re !== last_re || data_out_im !== last_im) begin
                errors++;
                $display("FAIL data_out n=%0d idx=%0d got %h/%h want %h/%h", n, idx,
                         data_out_re, data_out_im, last_re, last_im);
            end
            checks++;
            if ({sym_start, sym_end, last_sym} !== {exp_ss, exp_se, exp_ls}) begin
                errors++;
                $display("FAIL markers n=%0d idx=%0d got %b%b%b want %b%b%b", n, idx,
                         sym_start, sym_end, last_sym, exp_ss, exp_se, exp_ls);
            end
            checks++;
            if (finished !== exp_fin) begin
                errors++;
                $display("FAIL finished n=%0d idx=%0d got %b want %b", n, idx, finished, exp_fin);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_frame n=%0d idx=%0d got %b want 1", n, idx, busy);
            end
            if (clr_at_done && exp_fin)
                clear_Rx_irq = 1'b1;
            if (idx == abort_at)
                return;
            if (toggle || idx == stall_at) begin
                int gap;
                gap = toggle ? 1 : 1100;
                data_in_re = ~re_v;
                data_in_im = re_v;
                repeat (gap) @(posedge clk_ifft);
                #1;
                clear_Rx_irq = 1'b0;
                checks++;
                if (valid_out !== 1'b0 || finished !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_quiet n=%0d idx=%0d got v=%b f=%b want 0/0", n, idx,
                             valid_out, finished);
                end
                checks++;
                if (data_out_re !== last_re || data_out_im !== last_im) begin
                    errors++;
                    $display("FAIL gap_hold n=%0d idx=%0d got %h/%h want %h/%h", n, idx,
                             data_out_re, data_out_im, last_re, last_im);
                end
                checks++;
                if (busy !== !exp_fin) begin
                    errors++;
                    $display("FAIL gap_busy n=%0d idx=%0d got %b want %b", n, idx, busy, !exp_fin);
                end
            end
        end
        @(posedge clk_ifft); #1;
        clear_Rx_irq = 1'b0;
        checks++;
        if (busy !== 1'b0 || finished !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL frame_end n=%0d got busy=%b fin=%b v=%b want 0/0/0", n, busy,
                     finished, valid_out);
        end
    endtask

    task automatic test_reset;
        reset        = 1'b0;
        valid_in     = 1'b0;
        data_in_re   = '0;
        data_in_im   = '0;
        num_sym      = '0;
        en_Rx_irq    = 1'b0;
        clear_Rx_irq = 1'b0;
        repeat (3) @(posedge clk_ifft);
        #1;
        checks++;
        if ({valid_out, data_out_re, data_out_im, sym_start, sym_end, last_sym, finished,
             busy, Rx_irq, rx_err} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b re=%h im=%h busy=%b fin=%b irq=%b want all 0",
                     valid_out, data_out_re, data_out_im, busy, finished, Rx_irq);
        end
        reset = 1'b1;
        @(posedge clk_ifft); #1;
        checks++;
        if ({valid_out, finished, busy, Rx_irq, rx_err} !== 5'd0) begin
            errors++;
            $display("FAIL idle_after_reset got v=%b fin=%b busy=%b irq=%b err=%b want 0",
                     valid_out, finished, busy, Rx_irq, rx_err);
        end
    endtask

    task automatic test_continuous;
        drive_frame(2, 1'b0, -1, -1, 1'b0);
        checks++;
        if (Rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_disabled got %b want 0", Rx_irq);
        end
    endtask

    task automatic test_toggle;
        drive_frame(2, 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_zero_sym;
        drive_frame(0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_irq;
        en_Rx_irq = 1'b1;
        checks++;
        if (Rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_pre got %b want 0", Rx_irq);
        end
        drive_frame(1, 1'b0, -1, -1, 1'b0);
        checks++;
        if (Rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b want 1", Rx_irq);
        end
        en_Rx_irq = 1'b0;
        repeat (3) @(posedge clk_ifft);
        #1;
        checks++;
        if (Rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_sticky got %b want 1", Rx_irq);
        end
        clear_Rx_irq = 1'b1;
        @(posedge clk_ifft); #1;
        clear_Rx_irq = 1'b0;
        checks++;
        if (Rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b want 0", Rx_irq);
        end
        en_Rx_irq = 1'b1;
        drive_frame(1, 1'b0, -1, -1, 1'b1);
        checks++;
        if (Rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins got %b want 1", Rx_irq);
        end
        clear_Rx_irq = 1'b1;
        @(posedge clk_ifft); #1;
        clear_Rx_irq = 1'b0;
        en_Rx_irq    = 1'b0;
        checks++;
        if (Rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear2 got %b want 0", Rx_irq);
        end
    endtask

    task automatic test_reset_mid;
        drive_frame(2, 1'b0, PRE + CPL + 20, -1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        last_re = '0;
        last_im = '0;
        checks++;
        if ({valid_out, data_out_re, data_out_im, sym_start, sym_end, last_sym, finished,
             busy, Rx_irq, rx_err} !== 33'd0) begin
            errors++;
            $display("FAIL reset_mid got v=%b re=%h im=%h busy=%b fin=%b want all 0",
                     valid_out, data_out_re, data_out_im, busy, finished);
        end
        repeat (2) @(posedge clk_ifft);
        #1;
        reset = 1'b1;
        drive_frame(1, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_stall;
        drive_frame(1, 1'b0, -1, PRE + 5, 1'b0);
        checks++;
        if (rx_err !== 1'b0) begin
            errors++;
            $display("FAIL rx_err_tied got %b want 0", rx_err);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_zero_sym();
        test_irq();
        test_reset_mid();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
